load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one memory access at a time over a req/ready, rvalid memory port.
// Handles byte/half/word lanes, sign/zero extension and misaligned/unsupported faults.
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        is_write_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] load_q;

    logic        accept;
    logic        is_write_d;
    logic        bad_d;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_d;

    always_comb begin
        accept     = i_valid && (i_mem_read || i_mem_write);
        is_write_d = !i_mem_read;
        bad_d      = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111)
                  || (is_write_d && i_funct3[2])
                  || ((i_funct3[1:0] == 2'b01) && i_addr[0])
                  || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

        case (i_funct3[1:0])
            2'b00:   begin
                wmask_d = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_store_data[7:0]}};
            end
            2'b01:   begin
                wmask_d = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{i_store_data[15:0]}};
            end
            default: begin
                wmask_d = 4'b1111;
                wdata_d = i_store_data;
            end
        endcase

        lane = i_mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_d = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_d = {24'h0, lane[7:0]};
            3'b101:  load_d = {16'h0, lane[15:0]};
            default: load_d = lane;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            is_write_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            load_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= i_addr;
                        funct3_q   <= i_funct3;
                        is_write_q <= is_write_d;
                        wdata_q    <= wdata_d;
                        if (bad_d) begin
                            // Faulting accesses skip the memory port and complete next cycle.
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= is_write_d;
                            wmask_q   <= wmask_d;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        wmask_q   <= '0;
                        if (is_write_q) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        load_q  <= load_d;
                        state_q <= RESP;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = {addr_q[31:2], 2'b00};
    assign o_mem_wdata = wdata_q;
    assign o_mem_wmask = wmask_q;
    assign o_done      = done_q;
    assign o_fault     = fault_q;
    assign o_load_data = load_q;

endmodule
